// File: rtl/mask_stat_acc_if.sv
// mask_stat_acc_if: valid/ready output word stream of the wait-mask statistics accumulator
interface mask_stat_acc_if #(
   parameter int CNT_W = 16
) ();
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [CNT_W+15:0] out_data;
   modport master (output out_valid, output out_last, output out_data, input out_ready);
   modport slave  (input out_valid, input out_last, input out_data, output out_ready);
endinterface

// File: rtl/mask_stat_acc.sv
// mask_stat_acc: per-thread wait-mask cycle counters, snapshotted and streamed on dump (optional MASK_STAT_SKIP_ZERO_EN skips zero words)
module mask_stat_acc #(
   parameter int CNT_W  = 16,
   parameter int PERIOD = 1024
) (
   input  logic            clk,
   input  logic            rst_l,
   input  logic [3:0]      wm_imiss,
   input  logic [3:0]      wm_other,
   input  logic [3:0]      wm_stbwait,
   input  logic [3:0]      mul_wait,
   input  logic [3:0]      div_wait,
   input  logic [3:0]      fp_wait,
   input  logic [3:0]      mul_busy_e,
   input  logic [3:0]      div_busy_e,
   input  logic [3:0]      fp_busy_e,
   input  logic [3:0]      ldmiss,
   input  logic [9:0]      coreid,
   input  logic            dump_req,
   mask_stat_acc_if.master out_if
);
   localparam int N  = 40;
   localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [TW-1:0] TMAX = TW'(PERIOD - 1);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] live_q [N];
   logic [CNT_W-1:0] live_d [N];
   logic [CNT_W-1:0] shad_q [N];
   logic [CNT_W-1:0] shad_d [N];
   logic [TW-1:0]    timer_q, timer_d;
   logic [5:0]       idx_q, idx_d;
   logic             pend_q, pend_d;
   logic [9:0]       cid_q, cid_d;
   logic [N-1:0]     m;
   logic             trig, snap, skip, xfer;
   assign m    = {ldmiss, fp_busy_e, div_busy_e, mul_busy_e, fp_wait, div_wait, mul_wait, wm_stbwait, wm_other, wm_imiss};
   assign trig = dump_req || ((PERIOD != 0) && (timer_q == TMAX));
`ifdef MASK_STAT_SKIP_ZERO_EN
   assign skip = (state_q == STREAM) && (shad_q[idx_q] == '0) && (idx_q != 6'd39);
`else
   assign skip = 1'b0;
`endif
   assign out_if.out_valid = (state_q == STREAM) && !skip;
   assign out_if.out_last  = out_if.out_valid && (idx_q == 6'd39);
   assign out_if.out_data  = out_if.out_valid ? {cid_q, idx_q, shad_q[idx_q]} : '0;
   assign xfer = out_if.out_valid && out_if.out_ready;
   // Dump sequencing: snapshot on trigger or pending in IDLE, walk the shadow bank in STREAM
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = 1'b0;
      snap    = 1'b0;
      if (state_q == IDLE) begin
         snap    = trig || pend_q;
         state_d = snap ? STREAM : IDLE;
         idx_d   = 6'd0;
      end else begin
         pend_d  = pend_q || trig;
         idx_d   = (skip || xfer) ? idx_q + 6'd1 : idx_q;
         state_d = (xfer && idx_q == 6'd39) ? IDLE : STREAM;
      end
   end
   // Live counters saturate; on snapshot they restart from this cycle's bit so no cycle is lost
   always_comb begin
      timer_d = (timer_q == TMAX) ? '0 : timer_q + 1'b1;
      cid_d   = snap ? coreid : cid_q;
      for (int i = 0; i < N; i++) begin
         live_d[i] = snap ? CNT_W'(m[i]) : live_q[i] + CNT_W'(m[i] && !(&live_q[i]));
         shad_d[i] = snap ? live_q[i] : shad_q[i];
      end
   end
   // State register with asynchronous abort to reset values
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         cid_q   <= '0;
         for (int i = 0; i < N; i++) begin
            live_q[i] <= '0;
            shad_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         cid_q   <= cid_d;
         for (int i = 0; i < N; i++) begin
            live_q[i] <= live_d[i];
            shad_q[i] <= shad_d[i];
         end
      end
   end
endmodule
